// File: rtl/core_memory.sv
// core_memory
//
// 2**ADDR_W x DATA_W single-port synchronous RAM standing in for the
// MRAM/core array behind the MR0A16A wrapper. Reset starts a sweep that
// re-erases every word to INIT_WORD, one word per clock.
//
// Ports
//   address    word address, sampled on the rising edge of SIM_CLK
//   SIM_CLK    system clock
//   data       write data
//   wren       write enable, active-high (X/Z behaves as no write)
//   q          registered read data, one clock of latency, always driven
//   SIM_RST    asynchronous active-low reset
//   init_busy  high while the erase sweep runs; writes are ignored then
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_RUN  | normal read/write traffic
// ST_FILL | erase sweep: write INIT_WORD at fill_ptr, q held at 0
//
// The array holds (word ^ INIT_WORD). An all-zero array therefore reads
// back as erased, so power-up without any reset pulse is well defined and
// needs no init file; the sweep just writes zeros.

module core_memory #(
    parameter int                ADDR_W    = 11,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] INIT_WORD = 16'o40000
) (
    input  logic [ADDR_W-1:0] address,
    input  logic              SIM_CLK,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q,
    input  logic              SIM_RST,
    output logic              init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    // ST_RUN encodes as 0 so a zero power-up state means "ready".
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  fill_ptr;
    logic [ADDR_W-1:0]  fill_ptr_nxt;
    logic [DATA_W-1:0]  q_nxt;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  rd_word;

    logic [DATA_W-1:0]  mem [DEPTH];

    assign rd_word   = mem[address] ^ INIT_WORD;
    assign init_busy = (state == ST_FILL);

    always_comb begin
        state_nxt    = state;
        fill_ptr_nxt = fill_ptr;
        q_nxt        = q;
        mem_we       = 1'b0;
        mem_addr     = address;
        mem_wdata    = data ^ INIT_WORD;

        case (state)
            ST_FILL: begin
                mem_we       = 1'b1;
                mem_addr     = fill_ptr;
                mem_wdata    = '0;
                fill_ptr_nxt = fill_ptr + 1'b1;
                q_nxt        = '0;
                if (fill_ptr == {ADDR_W{1'b1}}) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                // An X/Z wren takes the else branch, i.e. a plain read.
                if (wren == 1'b1) begin
                    mem_we = 1'b1;
                    q_nxt  = data;
                end else begin
                    q_nxt  = rd_word;
                end
            end
        endcase
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state    <= ST_FILL;
            fill_ptr <= '0;
            q        <= '0;
        end else begin
            state    <= state_nxt;
            fill_ptr <= fill_ptr_nxt;
            q        <= q_nxt;
        end
    end

    // While reset is held the FSM sits in ST_FILL and would request a write
    // to word 0 every edge; SIM_RST gates that so the array stays untouched
    // until release.
    always_ff @(posedge SIM_CLK) begin
        if (mem_we && SIM_RST) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_core_memory.sv
module tb_core_memory;

    localparam int          AW    = 11;
    localparam int          DW    = 16;
    localparam int          DEPTH = 2 ** AW;
    localparam logic [15:0] ERASED = 16'o40000;

    logic          SIM_CLK = 1'b0;
    logic          SIM_RST = 1'b1;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data    = '0;
    logic          wren    = 1'b0;
    logic [DW-1:0] q;
    logic          init_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // reference contents: what each address must read back as
    logic [DW-1:0] model [DEPTH];

    core_memory dut (
        .address  (address),
        .SIM_CLK  (SIM_CLK),
        .data     (data),
        .wren     (wren),
        .q        (q),
        .SIM_RST  (SIM_RST),
        .init_busy(init_busy)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic erase_model();
        for (int i = 0; i < DEPTH; i++) model[i] = ERASED;
    endtask

    // One bus cycle: drive at the falling edge, let one rising edge pass,
    // check q at the next falling edge (one clock of read latency).
    task automatic op(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic we, input string tag);
        logic [DW-1:0] exp;
        address = a;
        data    = d;
        wren    = we;
        @(posedge SIM_CLK);
        if (we) begin
            model[a] = d;
            exp      = d;
        end else begin
            exp = model[a];
        end
        @(negedge SIM_CLK);
        check(tag, q, exp);
    endtask

    // Called at a falling edge. Asserts reset between edges, checks the
    // asynchronous effect, holds through two rising edges, releases at a
    // falling edge.
    task automatic pulse_reset(input string tag);
        #2 SIM_RST = 1'b0;
        #1;
        check({tag, "_q_async"}, q, 0);
        check({tag, "_busy_async"}, init_busy, 1);
        @(negedge SIM_CLK);
        @(negedge SIM_CLK);
        SIM_RST = 1'b1;
    endtask

    // Counts rising edges while init_busy stays high, attempting writes the
    // whole time. Stops after 'limit' edges. Returns with time at posedge+1.
    task automatic run_sweep(input int limit, output int n, output int q_bad);
        n       = 0;
        q_bad   = 0;
        address = 11'h060;
        data    = 16'h2222;
        wren    = 1'b1;
        while (init_busy === 1'b1 && n < limit) begin
            @(posedge SIM_CLK);
            n++;
            #1;
            if (q !== '0) q_bad++;
        end
        wren = 1'b0;
    endtask

    initial begin
        int n;
        int q_bad;
        logic [AW-1:0] a;
        logic [AW-1:0] ra;
        logic [DW-1:0] d;

        erase_model();
        @(negedge SIM_CLK);

        // power-up, no reset
        check("pwr_busy", init_busy, 0);
        op(11'd0,    16'h0, 1'b0, "pwr_rd_0");
        op(11'd1023, 16'h0, 1'b0, "pwr_rd_1023");
        op(11'd2047, 16'h0, 1'b0, "pwr_rd_2047");

        // directed write/read
        op(11'h000, 16'h1234, 1'b1, "wr_000");
        op(11'h7FF, 16'hABCD, 1'b1, "wr_7ff");
        op(11'h400, 16'h5555, 1'b1, "wr_400");
        op(11'h000, 16'hFFFF, 1'b0, "rd_000");
        op(11'h7FF, 16'h0000, 1'b0, "rd_7ff");
        op(11'h400, 16'h0000, 1'b0, "rd_400");
        op(11'h001, 16'h0000, 1'b0, "rd_001_nbr");
        op(11'h7FE, 16'h0000, 1'b0, "rd_7fe_nbr");

        // read-during-write and back-to-back writes to one address
        op(11'h010, 16'hBEEF, 1'b1, "rdw_010");
        op(11'h010, 16'h0000, 1'b0, "rd_010");
        op(11'h020, 16'h0001, 1'b1, "ww_first");
        op(11'h020, 16'h0002, 1'b1, "ww_second");
        op(11'h020, 16'h0000, 1'b0, "ww_rd");

        // reset and full sweep, with writes attempted during it
        op(11'h050, 16'h1111, 1'b1, "wr_050");
        pulse_reset("rst1");
        run_sweep(5000, n, q_bad);
        check("rst1_sweep_len", n, 2048);
        check("rst1_q_during_sweep", q_bad, 0);
        @(negedge SIM_CLK);
        erase_model();
        op(11'h050, 16'h0000, 1'b0, "rst1_rd_050");
        op(11'h060, 16'h0000, 1'b0, "rst1_rd_060");
        op(11'h7FF, 16'h0000, 1'b0, "rst1_rd_7ff");

        // reset again mid-sweep at sweep clock 1000
        op(11'h123, 16'h7777, 1'b1, "wr_123");
        pulse_reset("rst2");
        run_sweep(1000, n, q_bad);
        #2 SIM_RST = 1'b0;
        #1;
        check("rst2_mid_busy", init_busy, 1);
        check("rst2_mid_q", q, 0);
        @(negedge SIM_CLK);
        @(negedge SIM_CLK);
        SIM_RST = 1'b1;
        run_sweep(5000, n, q_bad);
        check("rst2_sweep_len", n, 2048);
        check("rst2_q_during_sweep", q_bad, 0);
        @(negedge SIM_CLK);
        erase_model();
        for (int i = 0; i < DEPTH; i++) begin
            op(AW'(i), 16'(i), 1'b0, "erase_all");
        end

        // back-to-back random write/read traffic
        for (int i = 0; i < 256; i++) begin
            a = AW'($urandom_range(0, DEPTH - 1));
            d = DW'($urandom);
            op(a, d, 1'b1, "rand_wr");
            ra = ($urandom_range(0, 1) == 1) ? a : AW'($urandom_range(0, DEPTH - 1));
            op(ra, DW'($urandom), 1'b0, "rand_rd");
        end
        check("end_busy", init_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
